// File: rtl/mstage_bus_if.sv
// -----------------------------------------------------------------------------
// mstage_bus_if
//   Handshake bundle between the execute stage (X side) and the memory stage
//   (M side).
//
//   X side : s_valid, s_ready, flush, aluresX, src2X, mvalidX, mwenX, mwmaskX,
//            mrtypeX, rdregsrcX, csrX, snpcX, pcX, rdX
//   M side : m_valid, m_ready, aluresM .. rdM (same widths as the X fields)
//
//   modport slave  : view of the pipeline register (mstage_bus)
//   modport master : view of the surrounding pipeline / stimulus
// -----------------------------------------------------------------------------
interface mstage_bus_if;
  logic        s_valid;
  logic        s_ready;
  logic        flush;

  logic [31:0] aluresX;
  logic [31:0] src2X;
  logic        mvalidX;
  logic        mwenX;
  logic [7:0]  mwmaskX;
  logic [2:0]  mrtypeX;
  logic [2:0]  rdregsrcX;
  logic [31:0] csrX;
  logic [31:0] snpcX;
  logic [31:0] pcX;
  logic [4:0]  rdX;

  logic        m_valid;
  logic        m_ready;

  logic [31:0] aluresM;
  logic [31:0] src2M;
  logic        mvalidM;
  logic        mwenM;
  logic [7:0]  mwmaskM;
  logic [2:0]  mrtypeM;
  logic [2:0]  rdregsrcM;
  logic [31:0] csrM;
  logic [31:0] snpcM;
  logic [31:0] pcM;
  logic [4:0]  rdM;

  modport slave (
    input  s_valid, flush, m_ready,
    input  aluresX, src2X, mvalidX, mwenX, mwmaskX, mrtypeX, rdregsrcX,
    input  csrX, snpcX, pcX, rdX,
    output s_ready, m_valid,
    output aluresM, src2M, mvalidM, mwenM, mwmaskM, mrtypeM, rdregsrcM,
    output csrM, snpcM, pcM, rdM
  );

  modport master (
    output s_valid, flush, m_ready,
    output aluresX, src2X, mvalidX, mwenX, mwmaskX, mrtypeX, rdregsrcX,
    output csrX, snpcX, pcX, rdX,
    input  s_ready, m_valid,
    input  aluresM, src2M, mvalidM, mwenM, mwmaskM, mrtypeM, rdregsrcM,
    input  csrM, snpcM, pcM, rdM
  );
endinterface

// File: rtl/mstage_bus.sv
// -----------------------------------------------------------------------------
// mstage_bus
//   Execute -> memory stage pipeline register with valid/ready handshake.
//   All eleven X fields travel together as one beat and appear on the M fields
//   the cycle after they are accepted.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : mstage_bus_if.slave (handshake, flush, X inputs, M outputs)
//
//   Parameter
//     RESET_PC : reset value of pcM and snpcM
//
//   Build option
//     MSTAGE_SKID_EN defined   : two-entry skid buffer (EMPTY/ONE/TWO), s_ready
//                                is a flop with no path from m_ready.
//     MSTAGE_SKID_EN undefined : single register (EMPTY/ONE), s_ready is
//                                !m_valid || m_ready.
// -----------------------------------------------------------------------------
module mstage_bus #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst,
  mstage_bus_if.slave bus
);

  typedef struct packed {
    logic [31:0] alures;
    logic [31:0] src2;
    logic        mvalid;
    logic        mwen;
    logic [7:0]  mwmask;
    logic [2:0]  mrtype;
    logic [2:0]  rdregsrc;
    logic [31:0] csr;
    logic [31:0] snpc;
    logic [31:0] pc;
    logic [4:0]  rd;
  } beat_t;

  localparam beat_t RESET_BEAT = '{32'd0, 32'd0, 1'b0, 1'b0, 8'd0, 3'd0, 3'd0,
                                   32'd0, RESET_PC, RESET_PC, 5'd0};

  beat_t beat_in;
  beat_t main_q;
  logic  xfer_in;
  logic  xfer_out;

  assign beat_in = {bus.aluresX, bus.src2X, bus.mvalidX, bus.mwenX, bus.mwmaskX,
                    bus.mrtypeX, bus.rdregsrcX, bus.csrX, bus.snpcX, bus.pcX,
                    bus.rdX};

  // M outputs always come from the main register.
  assign bus.aluresM   = main_q.alures;
  assign bus.src2M     = main_q.src2;
  assign bus.mvalidM   = main_q.mvalid;
  assign bus.mwenM     = main_q.mwen;
  assign bus.mwmaskM   = main_q.mwmask;
  assign bus.mrtypeM   = main_q.mrtype;
  assign bus.rdregsrcM = main_q.rdregsrc;
  assign bus.csrM      = main_q.csr;
  assign bus.snpcM     = main_q.snpc;
  assign bus.pcM       = main_q.pc;
  assign bus.rdM       = main_q.rd;

`ifdef MSTAGE_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q;
  beat_t  skid_q;
  logic   s_ready_q;
  logic   m_valid_q;

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign xfer_in     = bus.s_valid && s_ready_q;
  assign xfer_out    = m_valid_q && bus.m_ready;

  // s_ready_q and m_valid_q are kept as dedicated flops updated alongside the
  // state so neither output depends on m_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      main_q    <= RESET_BEAT;
      skid_q    <= RESET_BEAT;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // Flush beats everything, including a beat accepted this very cycle.
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_q    <= beat_in;
            state_q   <= ONE;
            m_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_q <= beat_in;
          end else if (xfer_in) begin
            // Downstream stalled: park the new beat behind the one on display.
            skid_q    <= beat_in;
            state_q   <= TWO;
            s_ready_q <= 1'b0;
          end else if (xfer_out) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (xfer_out) begin
            main_q    <= skid_q;
            state_q   <= ONE;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

`else

  typedef enum logic {EMPTY, ONE} state_t;

  state_t state_q;

  assign bus.m_valid = (state_q != EMPTY);
  // Without a skid slot the register may only refill when it is empty or being
  // drained in the same cycle.
  assign bus.s_ready = (state_q == EMPTY) || bus.m_ready;
  assign xfer_in     = bus.s_valid && bus.s_ready;
  assign xfer_out    = (state_q != EMPTY) && bus.m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_BEAT;
    end else if (bus.flush) begin
      state_q <= EMPTY;
    end else if (xfer_in) begin
      main_q  <= beat_in;
      state_q <= ONE;
    end else if (xfer_out) begin
      state_q <= EMPTY;
    end
  end

`endif

endmodule

// File: tb/tb_mstage_bus.sv
module tb_mstage_bus;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] alures;
    logic [31:0] src2;
    logic        mvalid;
    logic        mwen;
    logic [7:0]  mwmask;
    logic [2:0]  mrtype;
    logic [2:0]  rdregsrc;
    logic [31:0] csr;
    logic [31:0] snpc;
    logic [31:0] pc;
    logic [4:0]  rd;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mstage_bus_if bus ();

  mstage_bus #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Every field derived differently from the seed so swapped or stuck fields show.
  function automatic beat_t mk_beat(input logic [31:0] a);
    beat_t b;
    b.alures   = a;
    b.src2     = ~a;
    b.mvalid   = a[0];
    b.mwen     = ~a[1];
    b.mwmask   = a[7:0] ^ 8'h5A;
    b.mrtype   = a[2:0];
    b.rdregsrc = a[5:3] ^ 3'b101;
    b.csr      = a + 32'h0000_0100;
    b.snpc     = (a << 2) + 32'h4000_0004;
    b.pc       = (a << 2) | 32'h4000_0000;
    b.rd       = a[4:0] ^ 5'h1F;
    return b;
  endfunction

  function automatic beat_t got_beat();
    return {bus.aluresM, bus.src2M, bus.mvalidM, bus.mwenM, bus.mwmaskM,
            bus.mrtypeM, bus.rdregsrcM, bus.csrM, bus.snpcM, bus.pcM, bus.rdM};
  endfunction

  function automatic beat_t peek_exp();
    beat_t z;
    z = '0;
    if (exp_q.size() != 0) z = exp_q[0];
    return z;
  endfunction

  task automatic drive_beat(input logic valid, input beat_t b);
    bus.s_valid   = valid;
    bus.aluresX   = b.alures;
    bus.src2X     = b.src2;
    bus.mvalidX   = b.mvalid;
    bus.mwenX     = b.mwen;
    bus.mwmaskX   = b.mwmask;
    bus.mrtypeX   = b.mrtype;
    bus.rdregsrcX = b.rdregsrc;
    bus.csrX      = b.csr;
    bus.snpcX     = b.snpc;
    bus.pcX       = b.pc;
    bus.rdX       = b.rd;
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    drive_beat(1'b0, '0);
    #12;
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", bus.m_valid); end
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready); end
    n_checks++;
    if (bus.pcM !== RESET_PC) begin n_fail++; $display("FAIL reset_pcM: got %h required %h", bus.pcM, RESET_PC); end
    n_checks++;
    if (bus.snpcM !== RESET_PC) begin n_fail++; $display("FAIL reset_snpcM: got %h required %h", bus.snpcM, RESET_PC); end
    n_checks++;
    if (bus.aluresM !== 32'd0) begin n_fail++; $display("FAIL reset_aluresM: got %h required 0", bus.aluresM); end
    n_checks++;
    if (bus.rdM !== 5'd0) begin n_fail++; $display("FAIL reset_rdM: got %h required 0", bus.rdM); end
    n_checks++;
    if ({bus.src2M, bus.csrM, bus.mwmaskM, bus.mvalidM, bus.mwenM, bus.mrtypeM, bus.rdregsrcM} !== '0) begin
      n_fail++; $display("FAIL reset_other_fields: got %h required 0",
        {bus.src2M, bus.csrM, bus.mwmaskM, bus.mvalidM, bus.mwenM, bus.mrtypeM, bus.rdregsrcM});
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_streaming();
    beat_t b;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive_point();
      if (i <= 4) begin
        b = mk_beat(32'(i));
        drive_beat(1'b1, b);
        exp_q.push_back(b);
      end else begin
        drive_beat(1'b0, '0);
      end
      @(negedge clk);
      if (i <= 4) begin
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready%0d: got %b required 1", i, bus.s_ready); end
      end
      if (i > 1) begin
        n_checks++;
        if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL stream_m_valid%0d: got %b required 1", i, bus.m_valid); end
        n_checks++;
        if (bus.aluresM !== 32'(i - 1)) begin n_fail++; $display("FAIL stream_aluresM%0d: got %h required %h", i, bus.aluresM, 32'(i - 1)); end
        n_checks++;
        if (exp_q.size() == 0 || got_beat() !== peek_exp()) begin
          n_fail++; $display("FAIL stream_beat%0d: got %h required %h", i, got_beat(), peek_exp());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        $display("stream beat out alures=%h", bus.aluresM);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got m_valid %b required 0", bus.m_valid); end
  endtask

`ifdef MSTAGE_SKID_EN
  task automatic test_backpressure();
    beat_t a0, a1;
    a0 = mk_beat(32'hA0);
    a1 = mk_beat(32'hA1);
    bus.m_ready = 1'b0;
    drive_point();
    drive_beat(1'b1, a0);
    exp_q.push_back(a0);
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty: got %b required 1", bus.s_ready); end
    drive_point();
    drive_beat(1'b1, a1);
    exp_q.push_back(a1);
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b required 1", bus.s_ready); end
    drive_point();
    drive_beat(1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two%0d: got %b required 0", k, bus.s_ready); end
      n_checks++;
      if (bus.m_valid !== 1'b1 || got_beat() !== a0) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid %b beat %h required valid 1 beat %h", k, bus.m_valid, got_beat(), a0);
      end
      if (k == 0) drive_point();
    end
    drive_point();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b1 || exp_q.size() == 0 || got_beat() !== peek_exp()) begin
        n_fail++; $display("FAIL bp_drain%0d: got valid %b beat %h required %h", k, bus.m_valid, got_beat(), peek_exp());
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n_checks++;
      if (bus.s_ready !== (k == 1)) begin n_fail++; $display("FAIL bp_drain_ready%0d: got %b required %b", k, bus.s_ready, (k == 1)); end
      $display("backpressure beat out alures=%h", bus.aluresM);
      drive_point();
    end
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got m_valid %b required 0", bus.m_valid); end
  endtask
`else
  task automatic test_skid_off();
    beat_t a0, a1;
    a0 = mk_beat(32'hA0);
    a1 = mk_beat(32'hA1);
    bus.m_ready = 1'b0;
    drive_point();
    drive_beat(1'b1, a0);
    exp_q.push_back(a0);
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL noskid_ready_empty: got %b required 1", bus.s_ready); end
    drive_point();
    drive_beat(1'b1, a1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL noskid_ready_stall%0d: got %b required 0", k, bus.s_ready); end
      n_checks++;
      if (bus.m_valid !== 1'b1 || got_beat() !== a0) begin
        n_fail++; $display("FAIL noskid_hold%0d: got valid %b beat %h required valid 1 beat %h", k, bus.m_valid, got_beat(), a0);
      end
      drive_point();
    end
    bus.m_ready = 1'b1;
    exp_q.push_back(a1);
    #1;
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL noskid_ready_comb: got %b required 1", bus.s_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b1 || exp_q.size() == 0 || got_beat() !== peek_exp()) begin
        n_fail++; $display("FAIL noskid_drain%0d: got valid %b beat %h required %h", k, bus.m_valid, got_beat(), peek_exp());
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      $display("skid-off beat out alures=%h", bus.aluresM);
      drive_point();
      drive_beat(1'b0, '0);
    end
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL noskid_empty: got m_valid %b required 0", bus.m_valid); end
  endtask
`endif

  task automatic test_flush();
    beat_t c;
    bus.m_ready = 1'b0;
    drive_point();
    drive_beat(1'b1, mk_beat(32'hB0));
`ifdef MSTAGE_SKID_EN
    drive_point();
    drive_beat(1'b1, mk_beat(32'hB1));
`endif
    drive_point();
    bus.flush   = 1'b1;
    bus.m_ready = 1'b1;
    drive_beat(1'b1, mk_beat(32'hDEAD));
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_valid: got %b required 1", bus.m_valid); end
    drive_point();
    bus.flush = 1'b0;
    drive_beat(1'b0, '0);
    exp_q.delete();
    $display("flush applied, held beats discarded");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_beat%0d: got valid %b alures %h required valid 0", k, bus.m_valid, bus.aluresM);
      end
      if (k == 0) begin
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_s_ready: got %b required 1", bus.s_ready); end
      end
      drive_point();
    end
    c = mk_beat(32'hC0);
    drive_beat(1'b1, c);
    exp_q.push_back(c);
    drive_point();
    drive_beat(1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b1 || exp_q.size() == 0 || got_beat() !== peek_exp()) begin
      n_fail++; $display("FAIL flush_recover: got valid %b beat %h required %h", bus.m_valid, got_beat(), peek_exp());
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    $display("post-flush beat out alures=%h", bus.aluresM);
    drive_point();
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_recover_empty: got %b required 0", bus.m_valid); end
  endtask

  task automatic test_async_reset();
    beat_t e;
    bus.m_ready = 1'b0;
    drive_point();
    drive_beat(1'b1, mk_beat(32'hD0));
`ifdef MSTAGE_SKID_EN
    drive_point();
    drive_beat(1'b1, mk_beat(32'hD1));
`endif
    drive_point();
    drive_beat(1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL areset_m_valid: got %b required 0", bus.m_valid); end
    n_checks++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL areset_s_ready: got %b required 1", bus.s_ready); end
    n_checks++;
    if (bus.pcM !== RESET_PC || bus.aluresM !== 32'd0) begin
      n_fail++; $display("FAIL areset_fields: got pc %h alures %h required pc %h alures 0", bus.pcM, bus.aluresM, RESET_PC);
    end
    exp_q.delete();
    #2;
    rst = 1'b1;
    e = mk_beat(32'hE0);
    bus.m_ready = 1'b1;
    drive_beat(1'b1, e);
    exp_q.push_back(e);
    $display("async reset pulsed, beat E0 offered on first edge after release");
    drive_point();
    drive_beat(1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b1 || exp_q.size() == 0 || got_beat() !== peek_exp()) begin
      n_fail++; $display("FAIL areset_first_beat: got valid %b beat %h required %h", bus.m_valid, got_beat(), peek_exp());
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    drive_point();
    @(negedge clk);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_stale: got valid %b alures %h required valid 0", bus.m_valid, bus.aluresM); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
`ifdef MSTAGE_SKID_EN
    test_backpressure();
`else
    test_skid_off();
`endif
    test_flush();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mstage_bus.md
MSTAGE_BUS -- requirements
Module: mstage_bus

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000, reset value of pcM and snpcM.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 s_valid  input  1  execute stage presents a beat.
REQ-005 s_ready  output  1  block can accept a beat this cycle.
REQ-006 flush  input  1  synchronous discard of all held beats (trap/redirect).
REQ-007 aluresX  input  32  ALU result or memory address.
REQ-008 src2X  input  32  store data.
REQ-009 mvalidX, mwenX  input  1 each  memory access enable, memory write enable.
REQ-010 mwmaskX  input  8  write byte mask.
REQ-011 mrtypeX, rdregsrcX  input  3 each  load type, writeback source select.
REQ-012 csrX, snpcX, pcX  input  32 each  CSR read value, static next PC, instruction PC.
REQ-013 rdX  input  5  destination register.
REQ-014 aluresM..rdM  output  same widths  registered copies of the REQ-007..013 fields, X suffix replaced by M.
REQ-015 m_valid  output  1  output bundle holds a valid beat.
REQ-016 m_ready  input  1  memory stage consumes the beat.

Function
REQ-017 Transfer in = s_valid && s_ready; transfer out = m_valid && m_ready; all 11 fields move together as one beat.
REQ-018 Latency: a beat accepted at edge N appears on the M outputs after edge N, with zero bubbles at full throughput (one beat per cycle when m_ready is held high).
REQ-019 The FSM has three states: EMPTY (no beat), ONE (main register valid), TWO (main and skid registers valid).
REQ-020 EMPTY: in -> ONE; no in -> stay in EMPTY.
REQ-021 ONE: in and out -> ONE with the new beat in main; in only -> TWO with the new beat in skid; out only -> EMPTY; neither -> stay in ONE.
REQ-022 TWO: out -> ONE with skid moved to main; no out -> stay in TWO; no input is accepted in TWO.
REQ-023 m_valid = (state != EMPTY); the M outputs always drive the main register, never the skid register directly.
REQ-024 s_ready is a flop output equal to (state != TWO); no combinational path from m_ready to s_ready.
REQ-025 Beat order is strictly preserved; no beat is duplicated or dropped except by flush.
REQ-026 flush has priority over all other events: next state is EMPTY and any beat accepted in the same cycle is discarded; m_valid in the flush cycle still reflects the current state.
REQ-027 While m_valid=1 and m_ready=0, all M outputs hold stable.
REQ-028 Skid register contents are don't-care when not valid; main register contents are don't-care when state is EMPTY, except after reset (REQ-030).

Reset
REQ-029 rst=0 forces state EMPTY immediately, independent of clk: m_valid=0 and s_ready=1.
REQ-030 During reset, pcM=snpcM=RESET_PC and every other M output is 0.
REQ-031 Reset asserted mid-transfer discards both held beats; the first edge after rst deasserts may accept a beat.

Configuration
REQ-032 Macro MSTAGE_SKID_EN: when defined, the block implements REQ-019..024 (2-entry skid, registered s_ready).
REQ-033 When MSTAGE_SKID_EN is undefined, the block has a single register with states EMPTY/ONE only, s_ready = !m_valid || m_ready (combinational), and no skid storage; REQ-017, 018, 025..031 still apply.

Verification
REQ-034 Reset: rst=0 -> m_valid=0, s_ready=1, pcM=32'h80000000, aluresM=0, rdM=0.
REQ-035 Streaming: s_valid=1 and m_ready=1 for 4 cycles with aluresX=1,2,3,4 -> aluresM=1,2,3,4 on consecutive cycles, m_valid held at 1.
REQ-036 Backpressure (skid on): m_ready=0, push aluresX=A0 then A1 -> s_ready=0 after the second edge; then m_ready=1 -> outputs A0, then A1, then m_valid=0.
REQ-037 Flush: state TWO, then flush=1 with s_valid=1 and aluresX=0xDEAD -> next cycle m_valid=0, s_ready=1, and 0xDEAD is never presented.
REQ-038 Async reset: rst pulsed low between edges while in TWO -> m_valid falls before the next edge; no stale beat appears after release.
REQ-039 Skid off: m_ready=0 with m_valid=1 -> s_ready=0 in the same cycle; m_ready=1 -> s_ready=1 combinationally and the new beat replaces the old one at the edge.
